// File: rtl/one_wire_pkg.sv
// one_wire_pkg: shared 1-Wire FSM states, µs counter width and default µs timings
package one_wire_pkg;
  localparam int US_CNT_W = 9;
  localparam int T_RESET_US_DEF = 480;
  localparam int T_SAMPLE_START_US_DEF = 60;
  localparam int T_SAMPLE_END_US_DEF = 240;
  localparam int T_RECOVERY_US_DEF = 480;
  typedef enum logic [1:0] {IDLE, RESET_LOW, RELEASE, DONE} ow_state_e;
endpackage

// File: rtl/one_wire_us_tick.sv
// one_wire_us_tick: prescaler emitting a one-cycle pulse every CLKS_PER_US clocks
// Ports: clk, rst_n (async active-low), i_restart (sync restart to count 0), o_us_tick (last cycle of each µs)
module one_wire_us_tick #(
  parameter int CLKS_PER_US = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_restart,
  output logic o_us_tick
);
  localparam int W = CLKS_PER_US > 1 ? $clog2(CLKS_PER_US) : 1;
  logic [W-1:0] r_cnt;
  assign o_us_tick = r_cnt == W'(CLKS_PER_US - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_cnt <= '0;
    else r_cnt <= (i_restart || o_us_tick) ? '0 : r_cnt + 1'b1;
endmodule

// File: rtl/one_wire_reset_presence.sv
// one_wire_reset_presence: 1-Wire reset pulse generator with presence and short detection
// Ports: clk, rst_n (async active-low), en_reset_pulse (held request), bus (open-drain line),
//        done_reset_pulse (held until request drops), presence_detected, bus_short, busy
module one_wire_reset_presence
  import one_wire_pkg::*;
#(
  parameter int CLKS_PER_US = 1,
  parameter int T_RESET_US = T_RESET_US_DEF,
  parameter int T_SAMPLE_START_US = T_SAMPLE_START_US_DEF,
  parameter int T_SAMPLE_END_US = T_SAMPLE_END_US_DEF,
  parameter int T_RECOVERY_US = T_RECOVERY_US_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_reset_pulse,
  inout  wire  bus,
  output logic done_reset_pulse,
  output logic presence_detected,
  output logic bus_short,
  output logic busy
);
  ow_state_e r_state, w_next;
  logic [US_CNT_W-1:0] r_us;
  logic [1:0] r_sync;
  logic r_drive_low, r_presence, r_short;
  logic w_tick, w_restart, w_reset_end, w_release_end, w_in_window, w_bus_low, w_start, w_abort;
  one_wire_us_tick #(.CLKS_PER_US(CLKS_PER_US)) u_us_tick (
    .clk(clk),
    .rst_n(rst_n),
    .i_restart(w_restart),
    .o_us_tick(w_tick)
  );
  assign w_bus_low = ~r_sync[1];
  assign w_reset_end = w_tick && r_us == US_CNT_W'(T_RESET_US - 1);
  assign w_release_end = w_tick && r_us == US_CNT_W'(T_RECOVERY_US - 1);
  assign w_in_window = r_us >= US_CNT_W'(T_SAMPLE_START_US) && r_us < US_CNT_W'(T_SAMPLE_END_US);
  assign busy = r_state == RESET_LOW || r_state == RELEASE;
  assign done_reset_pulse = r_state == DONE;
  assign presence_detected = r_presence;
  assign bus_short = r_short;
  assign bus = r_drive_low ? 1'b0 : 1'bz;
  // every state entry restarts both the prescaler and the µs count so each phase is exact
  assign w_restart = w_next != r_state;
  assign w_start = r_state == IDLE && en_reset_pulse;
  assign w_abort = busy && !en_reset_pulse;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      w_next = en_reset_pulse ? RESET_LOW : IDLE;
      RESET_LOW: w_next = !en_reset_pulse ? IDLE : w_reset_end ? RELEASE : RESET_LOW;
      RELEASE:   w_next = !en_reset_pulse ? IDLE : w_release_end ? DONE : RELEASE;
      default:   w_next = en_reset_pulse ? DONE : IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_us <= '0;
      r_sync <= 2'b11;
      r_drive_low <= 1'b0;
      r_presence <= 1'b0;
      r_short <= 1'b0;
    end else begin
      r_us <= w_restart ? '0 : r_us + US_CNT_W'(w_tick);
      r_sync <= {r_sync[0], bus};
      r_drive_low <= w_next == RESET_LOW;
      if (w_start || w_abort) begin
        r_presence <= 1'b0;
        r_short <= 1'b0;
      end else if (r_state == RELEASE) begin
        if (w_in_window && w_bus_low) r_presence <= 1'b1;
        if (w_next == DONE) r_short <= w_bus_low;
      end
    end
endmodule

// File: tb/tb_one_wire_reset_presence.sv
// tb_one_wire_reset_presence: scoreboard bench for the 1-Wire reset/presence block
module tb_one_wire_reset_presence;
  typedef struct {
    int dur;
    int low;
    int done;
    int pres;
    int shrt;
  } exp_t;
  logic clk = 1'b0;
  logic rst1_n, rst4_n, en1, en4, slave1, slave4;
  wire bus1, bus4;
  logic done1, pres1, short1, busy1, done4, pres4, short4, busy4;
  int total = 0;
  int bad = 0;
  exp_t q[$];
  exp_t me;
  int mcyc = 0, mstart = 0, mlow = 0, pbusy = 0;
  int low4, n4;
  always #5 clk = ~clk;
  pullup (bus1);
  pullup (bus4);
  assign bus1 = slave1 ? 1'b0 : 1'bz;
  assign bus4 = slave4 ? 1'b0 : 1'bz;
  one_wire_reset_presence #(.CLKS_PER_US(1)) dut1 (
    .clk(clk),
    .rst_n(rst1_n),
    .en_reset_pulse(en1),
    .bus(bus1),
    .done_reset_pulse(done1),
    .presence_detected(pres1),
    .bus_short(short1),
    .busy(busy1)
  );
  one_wire_reset_presence #(.CLKS_PER_US(4)) dut4 (
    .clk(clk),
    .rst_n(rst4_n),
    .en_reset_pulse(en4),
    .bus(bus4),
    .done_reset_pulse(done4),
    .presence_detected(pres4),
    .bus_short(short4),
    .busy(busy4)
  );
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  function automatic int overlap(input int a, input int b, input int lo, input int hi);
    int l, h;
    l = a > lo ? a : lo;
    h = b < hi ? b : hi;
    return h > l ? h - l : 0;
  endfunction
  // Slave holds the line low during release-relative µs [a,b) (negative = during the reset low).
  // The synchronizer delays what the block sees by 2 µs, so the effective window is [58,238)
  // and the short check looks at the line as it was at µs 477. drop>0 releases the request in cycle drop.
  task automatic run_seq(input int a, input int b, input int drop);
    exp_t e;
    int last;
    last = drop > 0 ? drop + 1 : 961;
    e.dur = drop > 0 ? drop : 960;
    e.low = drop > 0 ? (drop < 480 ? drop : 480) : 480 - overlap(a, b, -480, 0);
    e.done = drop > 0 ? 0 : 1;
    e.pres = (drop == 0 && overlap(a, b, 58, 238) > 0) ? 1 : 0;
    e.shrt = (drop == 0 && a <= 477 && 477 < b) ? 1 : 0;
    q.push_back(e);
    en1 = 1'b1;
    for (int j = 1; j <= last; j++) begin
      @(posedge clk);
      #1;
      slave1 = (j - 481 >= a) && (j - 481 < b);
      if (drop > 0 && j == drop) en1 = 1'b0;
    end
    slave1 = 1'b0;
    if (drop > 0) begin
      chk("abort_bus_released", int'(bus1 === 1'b1), 1);
      chk("abort_busy", int'(busy1), 0);
      chk("abort_done", int'(done1), 0);
      chk("abort_presence", int'(pres1), 0);
      chk("abort_short", int'(short1), 0);
    end else begin
      chk("done_at_961", int'(done1), 1);
      @(posedge clk);
      #1;
      chk("done_held", int'(done1), 1);
      en1 = 1'b0;
      @(posedge clk);
      #1;
      chk("done_fall", int'(done1), 0);
      chk("presence_hold", int'(pres1), e.pres);
      chk("short_hold", int'(short1), e.shrt);
    end
    @(posedge clk);
    #1;
  endtask
  initial forever begin
    @(negedge clk);
    mcyc++;
    if (busy1 && pbusy == 0) begin
      mstart = mcyc;
      mlow = 0;
    end
    if (busy1 && bus1 === 1'b0 && !slave1) mlow++;
    if (!busy1 && pbusy != 0) begin
      if (q.size() == 0) chk("unexpected_end", 1, 0);
      else begin
        me = q.pop_front();
        chk("busy_duration", mcyc - mstart, me.dur);
        chk("low_cycles", mlow, me.low);
        chk("done", int'(done1), me.done);
        chk("presence", int'(pres1), me.pres);
        chk("short", int'(short1), me.shrt);
      end
    end
    pbusy = int'(busy1);
  end
  initial begin
    rst1_n = 1'b0;
    rst4_n = 1'b0;
    en1 = 1'b0;
    en4 = 1'b0;
    slave1 = 1'b0;
    slave4 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_done", int'(done1), 0);
    chk("rst_busy", int'(busy1), 0);
    chk("rst_presence", int'(pres1), 0);
    chk("rst_short", int'(short1), 0);
    chk("rst_bus", int'(bus1 === 1'b1), 1);
    rst1_n = 1'b1;
    rst4_n = 1'b1;
    @(posedge clk);
    #1;
    run_seq(30, 150, 0);
    run_seq(0, 0, 0);
    run_seq(10, 50, 0);
    run_seq(-480, 480, 0);
    run_seq(0, 0, 200);
    run_seq(0, 0, 0);
    run_seq(0, 0, 960);
    run_seq(0, 0, 1);
    run_seq(57, 58, 0);
    run_seq(58, 59, 0);
    run_seq(237, 238, 0);
    run_seq(238, 239, 0);
    run_seq(470, 480, 0);
    repeat (6) begin
      int a, b;
      a = int'($urandom_range(0, 519)) - 40;
      b = a + int'($urandom_range(1, 200));
      if (b > 480) b = 480;
      run_seq(a, b, 0);
    end
    repeat (3) run_seq(0, 0, int'($urandom_range(1, 960)));
    en4 = 1'b1;
    repeat (1000) @(posedge clk);
    #1;
    chk("c4_low_before_rst", int'(bus4 === 1'b0), 1);
    rst4_n = 1'b0;
    #1;
    chk("c4_rst_bus", int'(bus4 === 1'b1), 1);
    chk("c4_rst_busy", int'(busy4), 0);
    chk("c4_rst_done", int'(done4), 0);
    chk("c4_rst_presence", int'(pres4), 0);
    chk("c4_rst_short", int'(short4), 0);
    en4 = 1'b0;
    @(posedge clk);
    #1 rst4_n = 1'b1;
    @(posedge clk);
    #1;
    en4 = 1'b1;
    low4 = 0;
    n4 = 0;
    while (!done4 && n4 < 4000) begin
      @(posedge clk);
      #1;
      n4++;
      if (bus4 === 1'b0) low4++;
    end
    chk("c4_latency", n4, 3841);
    chk("c4_low_cycles", low4, 1920);
    chk("c4_presence", int'(pres4), 0);
    en4 = 1'b0;
    @(posedge clk);
    #1;
    chk("pending_expectations", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
